id_ex_stage: RTL and testbench

- Decode/execute pipeline register directly upstream of the 32-bit ALU.
- Latches decoded operands and control on each clock, and resolves data hazards.
- Drives the ALU's A, B and F inputs with forwarded operands: EX/MEM first, then MEM/WB, then the register file.
- Detects load-use hazards and inserts a bubble into EX.

---
 rtl/datapath_pkg.sv | 22 ++
 rtl/forward_unit.sv | 27 ++
 rtl/mux2.sv | 13 +
 rtl/mux4.sv | 25 ++
 rtl/id_ex_stage.sv | 111 +++++++++++
 tb/tb_id_ex_stage.sv | 215 +++++++++++++++++++++
 6 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath constants: widths, ALU function codes, forward-select codes.
package datapath_pkg;

  localparam int DP_N = 32;
  localparam int DP_R = 5;

  // ALU function codes carried on F
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Operand source selects produced by the forwarding unit
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Register 0 is hardwired zero and never forwards
  localparam logic [DP_R-1:0] REG_ZERO = '0;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select: EX/MEM beats MEM/WB beats register file; r0 never forwards.
module forward_unit
  import datapath_pkg::*;
#(
  parameter int R = DP_R
) (
  input  logic [R-1:0] rsE,
  input  logic [R-1:0] rtE,
  input  logic         exMemRegWrite,
  input  logic [R-1:0] exMemRd,
  input  logic         memWbRegWrite,
  input  logic [R-1:0] memWbRd,
  output logic [1:0]   fwdA,
  output logic [1:0]   fwdB
);

  logic mem_ok, wb_ok;

  assign mem_ok = exMemRegWrite && (exMemRd != '0);
  assign wb_ok  = memWbRegWrite && (memWbRd != '0);

  assign fwdA = (mem_ok && exMemRd == rsE) ? FWD_MEM :
                (wb_ok  && memWbRd == rsE) ? FWD_WB  : FWD_RF;
  assign fwdB = (mem_ok && exMemRd == rtE) ? FWD_MEM :
                (wb_ok  && memWbRd == rtE) ? FWD_WB  : FWD_RF;

endmodule

// File: rtl/mux2.sv
// Two-way N-bit multiplexer.
module mux2 #(
  parameter int N = 32
) (
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic         s,
  output logic [N-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/mux4.sv
// Four-way N-bit multiplexer.
module mux4 #(
  parameter int N = 32
) (
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  input  logic [1:0]   s,
  output logic [N-1:0] y
);

  // Plain select; every code maps to one input
  always_comb begin
    y = d0;
    case (s)
      2'b00: y = d0;
      2'b01: y = d1;
      2'b10: y = d2;
      2'b11: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding and load-use bubble insertion.
module id_ex_stage
  import datapath_pkg::*;
#(
  parameter int N = DP_N,
  parameter int R = DP_R
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inValid,
  input  logic [N-1:0] rd1,
  input  logic [N-1:0] rd2,
  input  logic [N-1:0] imm,
  input  logic [R-1:0] rs,
  input  logic [R-1:0] rt,
  input  logic [R-1:0] rdst,
  input  logic         useRt,
  input  logic         aluSrc,
  input  logic [2:0]   aluCtl,
  input  logic         regWrite,
  input  logic         memWrite,
  input  logic         memToReg,
  input  logic         stall,
  input  logic         flush,
  input  logic         exMemRegWrite,
  input  logic [R-1:0] exMemRd,
  input  logic [N-1:0] exMemY,
  input  logic         memWbRegWrite,
  input  logic [R-1:0] memWbRd,
  input  logic [N-1:0] memWbY,
  output logic [N-1:0] SrcA,
  output logic [N-1:0] SrcB,
  output logic [2:0]   F,
  output logic [N-1:0] WriteDataE,
  output logic         validE,
  output logic         regWriteE,
  output logic         memWriteE,
  output logic         memToRegE,
  output logic [R-1:0] rdE,
  output logic         luStall
);

  logic [N-1:0] rd1E, rd2E, immE;
  logic [R-1:0] rsE, rtE;
  logic         aluSrcE;
  logic [1:0]   fwdA, fwdB;
  logic [N-1:0] fwd_b;

  // A load in EX whose destination is read by the incoming instruction
  assign luStall = inValid && validE && memToRegE && (rdE != REG_ZERO) &&
                   ((rdE == rs) || (useRt && (rdE == rt)));

  // Pipeline register: reset/flush/load-use load a bubble, stall holds
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && luStall)) begin
      validE    <= 1'b0;
      rd1E      <= '0;
      rd2E      <= '0;
      immE      <= '0;
      rsE       <= '0;
      rtE       <= '0;
      rdE       <= '0;
      aluSrcE   <= 1'b0;
      F         <= 3'b000;
      regWriteE <= 1'b0;
      memWriteE <= 1'b0;
      memToRegE <= 1'b0;
    end else if (!stall) begin
      validE    <= inValid;
      rd1E      <= rd1;
      rd2E      <= rd2;
      immE      <= imm;
      rsE       <= rs;
      rtE       <= rt;
      rdE       <= rdst;
      aluSrcE   <= aluSrc;
      F         <= aluCtl;
      regWriteE <= regWrite;
      memWriteE <= memWrite;
      memToRegE <= memToReg;
    end
  end

  forward_unit #(.R(R)) u_fwd (
    .rsE          (rsE),
    .rtE          (rtE),
    .exMemRegWrite(exMemRegWrite),
    .exMemRd      (exMemRd),
    .memWbRegWrite(memWbRegWrite),
    .memWbRd      (memWbRd),
    .fwdA         (fwdA),
    .fwdB         (fwdB)
  );

  // Unused select code 11 falls back to the register value
  mux4 #(.N(N)) u_mux_a (
    .d0(rd1E), .d1(memWbY), .d2(exMemY), .d3(rd1E), .s(fwdA), .y(SrcA)
  );

  mux4 #(.N(N)) u_mux_b (
    .d0(rd2E), .d1(memWbY), .d2(exMemY), .d3(rd2E), .s(fwdB), .y(fwd_b)
  );

  mux2 #(.N(N)) u_mux_imm (
    .d0(fwd_b), .d1(immE), .s(aluSrcE), .y(SrcB)
  );

  // Store data is always the forwarded rt value
  assign WriteDataE = fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then randomized traffic vs a reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, inValid, useRt, aluSrc, regWrite, memWrite, memToReg;
  logic        stall, flush, exMemRegWrite, memWbRegWrite;
  logic [31:0] rd1, rd2, imm, exMemY, memWbY;
  logic [4:0]  rs, rt, rdst, exMemRd, memWbRd;
  logic [2:0]  aluCtl;
  logic [31:0] SrcA, SrcB, WriteDataE;
  logic [2:0]  F;
  logic        validE, regWriteE, memWriteE, memToRegE, luStall;
  logic [4:0]  rdE;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .inValid(inValid), .rd1(rd1), .rd2(rd2), .imm(imm),
    .rs(rs), .rt(rt), .rdst(rdst), .useRt(useRt), .aluSrc(aluSrc), .aluCtl(aluCtl),
    .regWrite(regWrite), .memWrite(memWrite), .memToReg(memToReg),
    .stall(stall), .flush(flush),
    .exMemRegWrite(exMemRegWrite), .exMemRd(exMemRd), .exMemY(exMemY),
    .memWbRegWrite(memWbRegWrite), .memWbRd(memWbRd), .memWbY(memWbY),
    .SrcA(SrcA), .SrcB(SrcB), .F(F), .WriteDataE(WriteDataE),
    .validE(validE), .regWriteE(regWriteE), .memWriteE(memWriteE),
    .memToRegE(memToRegE), .rdE(rdE), .luStall(luStall)
  );

  // Reference view of the instruction sitting in EX
  typedef struct {
    bit       valid;
    bit [31:0] a, b, imm;
    bit [4:0] rs, rt, rd;
    bit       alu_src;
    bit [2:0] ctl;
    bit       rw, mw, m2r;
  } ex_t;

  ex_t m;
  ex_t bubble;

  // Value an instruction sees for source register idx (its own register-file copy is rf)
  function automatic logic [31:0] operand(input bit [4:0] idx, input bit [31:0] rf);
    if (idx == 0) return rf;
    if (exMemRegWrite && exMemRd == idx) return exMemY;
    if (memWbRegWrite && memWbRd == idx) return memWbY;
    return rf;
  endfunction

  function automatic bit hazard();
    if (!(inValid && m.valid && m.m2r) || m.rd == 0) return 0;
    return (m.rd == rs) || (useRt && m.rd == rt);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] b;
    b = operand(m.rt, m.b);
    chk("SrcA",       SrcA,       operand(m.rs, m.a));
    chk("SrcB",       SrcB,       m.alu_src ? m.imm : b);
    chk("WriteDataE", WriteDataE, b);
    chk("F",          {29'd0, F},        {29'd0, m.ctl});
    chk("validE",     {31'd0, validE},   {31'd0, m.valid});
    chk("regWriteE",  {31'd0, regWriteE},{31'd0, m.rw});
    chk("memWriteE",  {31'd0, memWriteE},{31'd0, m.mw});
    chk("memToRegE",  {31'd0, memToRegE},{31'd0, m.m2r});
    chk("rdE",        {27'd0, rdE},      {27'd0, m.rd});
    chk("luStall",    {31'd0, luStall},  {31'd0, hazard()});
  endtask

  // Advance one clock, updating the model with the same priority the stage obeys
  task automatic tick();
    ex_t nxt;
    if (reset || flush) nxt = bubble;
    else if (stall) nxt = m;
    else if (hazard()) nxt = bubble;
    else begin
      nxt.valid = inValid; nxt.a = rd1; nxt.b = rd2; nxt.imm = imm;
      nxt.rs = rs; nxt.rt = rt; nxt.rd = rdst; nxt.alu_src = aluSrc;
      nxt.ctl = aluCtl; nxt.rw = regWrite; nxt.mw = memWrite; nxt.m2r = memToReg;
    end
    @(posedge clk);
    m = nxt;
    #1;
  endtask

  task automatic clear_inputs();
    inValid = 0; rd1 = 0; rd2 = 0; imm = 0; rs = 0; rt = 0; rdst = 0;
    useRt = 0; aluSrc = 0; aluCtl = 0; regWrite = 0; memWrite = 0; memToReg = 0;
    stall = 0; flush = 0; exMemRegWrite = 0; exMemRd = 0; exMemY = 0;
    memWbRegWrite = 0; memWbRd = 0; memWbY = 0;
  endtask

  initial begin
    bubble = '{default: 0};
    m = bubble;
    clear_inputs();

    // Reset for two cycles, then released with nothing valid
    reset = 1;
    tick(); tick();
    reset = 0; #1;
    chk("rst_validE", {31'd0, validE}, 32'd0);
    chk("rst_SrcA", SrcA, 32'd0);
    chk("rst_SrcB", SrcB, 32'd0);
    chk("rst_luStall", {31'd0, luStall}, 32'd0);
    check_model();

    // Plain load, no hazards
    inValid = 1; rd1 = 5; rd2 = 7; aluCtl = 3'b010; rs = 1; rt = 2; rdst = 6;
    useRt = 1; regWrite = 1;
    tick();
    inValid = 0; #1;
    chk("load_SrcA", SrcA, 32'd5);
    chk("load_SrcB", SrcB, 32'd7);
    chk("load_F", {29'd0, F}, 32'd2);
    chk("load_validE", {31'd0, validE}, 32'd1);
    check_model();

    // Forwarding priority on A
    inValid = 1; rs = 3; rd1 = 32'h99;
    tick();
    exMemRegWrite = 1; exMemRd = 3; exMemY = 32'h10;
    memWbRegWrite = 1; memWbRd = 3; memWbY = 32'h20; #1;
    chk("fwd_mem_wins", SrcA, 32'h10);
    check_model();
    exMemRegWrite = 0; #1;
    chk("fwd_wb", SrcA, 32'h20);
    check_model();
    rs = 0; rd1 = 32'h55; exMemRegWrite = 0;
    tick();
    exMemRegWrite = 1; exMemRd = 0; memWbRd = 0; #1;
    chk("fwd_r0", SrcA, 32'h55);
    check_model();
    exMemRegWrite = 0; memWbRegWrite = 0;

    // Load-use on rs
    inValid = 1; memToReg = 1; rdst = 4; rs = 1; rt = 2;
    tick();
    rs = 4; memToReg = 0; rdst = 5; #1;
    chk("lu_rs", {31'd0, luStall}, 32'd1);
    check_model();
    tick();
    chk("lu_bubble_valid", {31'd0, validE}, 32'd0);
    chk("lu_bubble_m2r", {31'd0, memToRegE}, 32'd0);
    chk("lu_once", {31'd0, luStall}, 32'd0);
    check_model();

    // rt match only counts when rt is actually read
    memToReg = 1; rdst = 4; rs = 1;
    tick();
    memToReg = 0; rs = 1; rt = 4; useRt = 0; #1;
    chk("lu_rt_unused", {31'd0, luStall}, 32'd0);
    useRt = 1; #1;
    chk("lu_rt_used", {31'd0, luStall}, 32'd1);
    check_model();
    useRt = 0;
    tick();

    // Stall freezes the stage while inputs move
    rd1 = 32'hA; rd2 = 32'hB; rs = 7; rt = 8; rdst = 9; aluCtl = 3'b110; regWrite = 1;
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rd1 = $urandom; rd2 = $urandom; aluCtl = 3'b001; rdst = 5'(i + 10);
      tick();
      chk("stall_SrcA", SrcA, 32'hA);
      chk("stall_F", {29'd0, F}, 32'd6);
      check_model();
    end
    flush = 1;
    tick();
    chk("flush_regWriteE", {31'd0, regWriteE}, 32'd0);
    chk("flush_validE", {31'd0, validE}, 32'd0);
    check_model();
    flush = 0;
    tick();
    reset = 1;
    tick();
    chk("rst_in_stall", {31'd0, validE}, 32'd0);
    check_model();
    reset = 0; stall = 0;

    // Randomized traffic with a small register pool so hazards recur
    for (int i = 0; i < 400; i++) begin
      inValid = ($urandom_range(0, 3) != 0);
      rd1 = $urandom; rd2 = $urandom; imm = $urandom;
      rs = 5'($urandom_range(0, 4)); rt = 5'($urandom_range(0, 4));
      rdst = 5'($urandom_range(0, 4));
      useRt = 1'($urandom); aluSrc = 1'($urandom); aluCtl = 3'($urandom);
      regWrite = 1'($urandom); memWrite = 1'($urandom); memToReg = 1'($urandom);
      stall = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 49) == 0);
      exMemRegWrite = 1'($urandom); exMemRd = 5'($urandom_range(0, 4)); exMemY = $urandom;
      memWbRegWrite = 1'($urandom); memWbRd = 5'($urandom_range(0, 4)); memWbY = $urandom;
      #1;
      check_model();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
